ofm_store_ctrl: RTL and testbench

- Downstream neighbour of the OFM packing buffer. Consumes its 32-bit packed words: tag byte [31:24] plus three 8-bit results in [23:0].
- Buffers the words in a small FIFO and writes each payload to the on-chip output SRAM.
- Addresses are generated separately for the convolution and pooling streams.
- Tracks the per-frame word count and reports frame completion and errors to the top-level controller.

---
 rtl/ofm_store_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ofm_store_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_store_ctrl.sv
// OFM store controller: captures packed words from the OFM buffer, queues them
// in a small FIFO and writes payloads to the output SRAM with per-stream addressing.
module ofm_store_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] CONV_BASE = ADDR_WIDTH'(16'h0000),
    parameter logic [ADDR_WIDTH-1:0] POOL_BASE = ADDR_WIDTH'(16'h8000),
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [31:0]           ofm_word,
    input  logic                  word_full,
    input  logic                  mem_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [23:0]           mem_wdata,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  tag_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_word_full_d;
    logic [LEN_WIDTH-1:0]  r_frame_len;
    logic [LEN_WIDTH-1:0]  r_acc_cnt;
    logic [LEN_WIDTH-1:0]  r_words_done;
    logic [ADDR_WIDTH-1:0] r_conv_off;
    logic [ADDR_WIDTH-1:0] r_pool_off;
    logic                  r_overflow;
    logic                  r_tag_err;

    // Entry layout: bit 24 = stream (1 = pool), bits 23:0 = payload.
    logic [24:0]           r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push_req;
    logic                  w_tag_conv;
    logic                  w_tag_pool;
    logic                  w_push;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_drop;
    logic                  w_start;
    logic [LEN_WIDTH-1:0]  w_acc_next;
    logic [24:0]           w_head;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_tag_conv = (ofm_word[31:24] == 8'h00);
    assign w_tag_pool = (ofm_word[31:24] == 8'hFF);
    assign w_push_req = word_full & ~r_word_full_d & (r_state == RUN);
    assign w_push     = w_push_req & (w_tag_conv | w_tag_pool);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_wr_en    = (r_count != '0) & ((r_state == RUN) | (r_state == DRAIN));
    assign w_pop      = w_wr_en & mem_ready;
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_start    = frame_start & ((r_state == IDLE) | (r_state == DONE));
    assign w_acc_next = r_acc_cnt + LEN_WIDTH'(w_push_req);

    assign w_head = r_fifo[r_rd_ptr];
    assign w_addr = w_head[24] ? (POOL_BASE + r_pool_off) : (CONV_BASE + r_conv_off);

    assign mem_wr_en  = w_wr_en;
    assign mem_addr   = w_wr_en ? w_addr : '0;
    assign mem_wdata  = w_wr_en ? w_head[23:0] : '0;
    assign words_done = r_words_done;
    assign busy       = (r_state == RUN) | (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign overflow   = r_overflow;
    assign tag_err    = r_tag_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (frame_start) w_next = RUN;
            RUN:   if (w_acc_next == r_frame_len) w_next = DRAIN;
            // Captures are off in DRAIN, so only a pop can change the count.
            DRAIN: if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) w_next = DONE;
            DONE:  if (frame_start) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= {w_tag_pool, ofm_word[23:0]};
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_full_d <= 1'b0;
            r_frame_len   <= '0;
            r_acc_cnt     <= '0;
            r_words_done  <= '0;
            r_conv_off    <= '0;
            r_pool_off    <= '0;
            r_overflow    <= 1'b0;
            r_tag_err     <= 1'b0;
        end else begin
            r_word_full_d <= word_full;
            if (w_start) begin
                r_frame_len  <= frame_len;
                r_acc_cnt    <= '0;
                r_words_done <= '0;
                r_conv_off   <= '0;
                r_pool_off   <= '0;
                r_overflow   <= 1'b0;
                r_tag_err    <= 1'b0;
            end else begin
                r_acc_cnt <= w_acc_next;
                if (w_pop) begin
                    r_words_done <= r_words_done + LEN_WIDTH'(1);
                    if (w_head[24]) begin
                        r_pool_off <= r_pool_off + ADDR_WIDTH'(1);
                    end else begin
                        r_conv_off <= r_conv_off + ADDR_WIDTH'(1);
                    end
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_push_req && !(w_tag_conv || w_tag_pool)) begin
                    r_tag_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_store_ctrl.sv
// Self-checking bench for ofm_store_ctrl: table-driven frames plus hand-written
// sequences, with a write scoreboard checked on every SRAM write.
module tb_ofm_store_ctrl;

    localparam logic [15:0] CB = 16'h0000;
    localparam logic [15:0] PB = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [15:0] frame_len;
    logic [31:0] ofm_word;
    logic        word_full;
    logic        mem_ready;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [15:0] words_done;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        tag_err;

    ofm_store_ctrl #(
        .ADDR_WIDTH(16),
        .FIFO_DEPTH(4),
        .CONV_BASE (CB),
        .POOL_BASE (PB),
        .LEN_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .frame_len  (frame_len),
        .ofm_word   (ofm_word),
        .word_full  (word_full),
        .mem_ready  (mem_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .words_done (words_done),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .tag_err    (tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [23:0] exp_data;
        logic        exp_tag_err;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [23:0] data;
    } wr_t;

    vec_t        tbl [7];
    wr_t         sb [$];
    int          checks   = 0;
    int          failures = 0;
    int          n_writes = 0;
    logic [15:0] m_conv;
    logic [15:0] m_pool;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic        mp_pend = 1'b0;
    logic [15:0] mp_addr;
    logic [23:0] mp_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            mp_pend = 1'b0;
        end else begin
            if (mp_pend) begin
                check("hold_wr_en", 64'(mem_wr_en), 64'(1));
                check("hold_addr", 64'(mem_addr), 64'(mp_addr));
                check("hold_data", 64'(mem_wdata), 64'(mp_data));
            end
            if (mem_wr_en && mem_ready) begin
                n_writes++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata), 64'(e.data));
                end
            end
            mp_pend = mem_wr_en && !mem_ready;
            mp_addr = mem_addr;
            mp_data = mem_wdata;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse(input logic [15:0] len);
        frame_len   = len;
        frame_start = 1'b1;
        m_conv      = '0;
        m_pool      = '0;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w);
        if (w[31:24] == 8'hFF) begin
            sb.push_back('{PB + m_pool, w[23:0]});
            m_pool = m_pool + 16'd1;
        end else if (w[31:24] == 8'h00) begin
            sb.push_back('{CB + m_conv, w[23:0]});
            m_conv = m_conv + 16'd1;
        end
    endtask

    task automatic capture(input logic [31:0] w, input logic kept);
        ofm_word  = w;
        word_full = 1'b1;
        if (kept) expect_word(w);
        cyc();
        word_full = 1'b0;
        cyc();
    endtask

    task automatic capture_row(input vec_t v);
        ofm_word  = v.word;
        word_full = 1'b1;
        if (v.exp_wr) sb.push_back('{v.exp_addr, v.exp_data});
        cyc();
        word_full = 1'b0;
        cyc();
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            cyc();
            n++;
        end
        check(name, 64'(done), 64'(1));
    endtask

    initial begin
        tbl[0] = '{32'h00112233, 1'b1, 16'h0000, 24'h112233, 1'b0};
        tbl[1] = '{32'h00445566, 1'b1, 16'h0001, 24'h445566, 1'b0};
        tbl[2] = '{32'hFF778899, 1'b1, PB,       24'h778899, 1'b0};
        tbl[3] = '{32'h5A010203, 1'b0, 16'h0000, 24'h000000, 1'b1};
        tbl[4] = '{32'h00000001, 1'b1, 16'h0000, 24'h000001, 1'b1};
        tbl[5] = '{32'hFF102030, 1'b1, PB,       24'h102030, 1'b1};
        tbl[6] = '{32'h000000FF, 1'b1, 16'h0001, 24'h0000FF, 1'b1};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_len   = '0;
        ofm_word    = '0;
        word_full   = 1'b0;
        mem_ready   = 1'b1;
        repeat (3) cyc();
        check("reset_outputs",
              64'({mem_wr_en, mem_addr, mem_wdata, words_done, busy, done, overflow, tag_err}),
              64'(0));
        rst_n = 1'b1;
        cyc();

        // Basic frame of three words.
        frame_pulse(16'd3);
        check("run_busy", 64'(busy), 64'(1));
        for (int i = 0; i < 3; i++) begin
            capture_row(tbl[i]);
            check("row_tag_err", 64'(tag_err), 64'(tbl[i].exp_tag_err));
        end
        check("t1_done", 64'(done), 64'(1));
        check("t1_busy", 64'(busy), 64'(0));
        check("t1_words_done", 64'(words_done), 64'(3));
        check("t1_sb_empty", 64'(sb.size()), 64'(0));

        // Level held high gives a single capture.
        frame_pulse(16'd2);
        begin
            int w0;
            w0 = n_writes;
            ofm_word  = 32'h00AABBCC;
            word_full = 1'b1;
            expect_word(ofm_word);
            repeat (10) cyc();
            word_full = 1'b0;
            cyc();
            check("t2_one_write", 64'(n_writes - w0), 64'(1));
            check("t2_still_run", 64'(busy), 64'(1));
            check("t2_not_done", 64'(done), 64'(0));
        end
        capture(32'h00DDEEFF, 1'b1);
        wait_done("t2_done", 5);
        check("t2_words_done", 64'(words_done), 64'(2));

        // Overflow with a stalled SRAM.
        mem_ready = 1'b0;
        frame_pulse(16'd6);
        for (int i = 0; i < 6; i++) begin
            capture(32'h00A00000 + 32'(i), i < 4);
        end
        check("t3_overflow", 64'(overflow), 64'(1));
        check("t3_busy", 64'(busy), 64'(1));
        check("t3_words_done0", 64'(words_done), 64'(0));
        capture(32'h00EEEEEE, 1'b0);
        mem_ready = 1'b1;
        wait_done("t3_done", 20);
        check("t3_words_done", 64'(words_done), 64'(4));
        check("t3_sb_empty", 64'(sb.size()), 64'(0));

        // Bad tag counts toward the frame but is not written.
        frame_pulse(16'd4);
        check("t4_overflow_cleared", 64'(overflow), 64'(0));
        for (int i = 3; i < 7; i++) begin
            capture_row(tbl[i]);
            check("row_tag_err", 64'(tag_err), 64'(tbl[i].exp_tag_err));
        end
        wait_done("t4_done", 5);
        check("t4_words_done", 64'(words_done), 64'(3));
        check("t4_tag_err_sticky", 64'(tag_err), 64'(1));

        // Push and pop together on a full FIFO; pool addresses wrap past FFFF.
        mem_ready = 1'b0;
        frame_pulse(16'd12);
        check("t5_tag_err_cleared", 64'(tag_err), 64'(0));
        for (int i = 0; i < 4; i++) begin
            capture({(i % 2 == 1) ? 8'h00 : 8'hFF, 24'h5C0000 + 24'(i)}, 1'b1);
        end
        for (int i = 4; i < 12; i++) begin
            ofm_word  = {(i % 2 == 1) ? 8'h00 : 8'hFF, 24'h5C0000 + 24'(i)};
            word_full = 1'b1;
            mem_ready = 1'b1;
            expect_word(ofm_word);
            cyc();
            word_full = 1'b0;
            mem_ready = 1'b0;
            cyc();
        end
        check("t5_no_overflow", 64'(overflow), 64'(0));
        mem_ready = 1'b1;
        wait_done("t5_done", 20);
        check("t5_words_done", 64'(words_done), 64'(12));
        check("t5_sb_empty", 64'(sb.size()), 64'(0));

        // Asynchronous reset with queued entries, then an empty frame.
        mem_ready = 1'b0;
        frame_pulse(16'd5);
        capture(32'h00111111, 1'b1);
        capture(32'hFF222222, 1'b1);
        check("t6_pending", 64'(mem_wr_en), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              64'({mem_wr_en, mem_addr, mem_wdata, words_done, busy, done, overflow, tag_err}),
              64'(0));
        sb.delete();
        cyc();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        begin
            int w0;
            w0 = n_writes;
            cyc();
            check("t6_no_wr_after_reset", 64'(mem_wr_en), 64'(0));
            frame_pulse(16'd0);
            wait_done("t6_done_len0", 3);
            check("t6_no_writes", 64'(n_writes - w0), 64'(0));
            check("t6_words_done", 64'(words_done), 64'(0));
        end

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
